// File: rtl/r88_int_sequencer_pkg.sv
// Shared definitions for the Rocket88 interrupt sequencer: state encoding,
// default vector addresses and flag-byte helpers.
package r88_int_sequencer_pkg;

   typedef enum logic [3:0] {
      RST_LO,
      RST_HI,
      IDLE,
      PUSH_PCH,
      PUSH_PCL,
      PUSH_FLG,
      VEC_LO,
      VEC_HI,
      LOAD_PC
   } seq_state_e;

   localparam logic [15:0] RESET_VEC_DEF = 16'hFFFC;
   localparam logic [15:0] NMI_VEC_DEF   = 16'hFFFA;
   localparam logic [15:0] IRQ_VEC_DEF   = 16'hFFFE;
   localparam int          FLAG_BRK      = 4;

   // Break bit distinguishes BRK from hardware entry in the stacked flags.
   function automatic logic [7:0] push_flags(input logic [7:0] flags, input logic brk);
      logic [7:0] res;
      res           = flags;
      res[FLAG_BRK] = brk;
      return res;
   endfunction

endpackage

// File: rtl/r88_int_sequencer_nmi_edge.sv
// NMI rising-edge detector: registers the request, flags a 0->1 transition
// as pending and holds it until the sequencer selects NMI service.
module r88_nmi_edge (
   input  logic sysClock_i,
   input  logic resetReq_i,
   input  logic nmiReq_i,
   input  logic nmiClr_i,
   output logic nmiPend_o
);

   logic nmiReq_q;
   logic nmiPrev_q;
   logic nmiPend_q;

   always_ff @(posedge sysClock_i) begin
      if (resetReq_i) begin
         nmiReq_q  <= 1'b0;
         nmiPrev_q <= 1'b0;
         nmiPend_q <= 1'b0;
      end else begin
         nmiReq_q  <= nmiReq_i;
         nmiPrev_q <= nmiReq_q;
         // A fresh edge wins over a same-cycle clear so it is never lost.
         if (nmiReq_q && !nmiPrev_q) begin
            nmiPend_q <= 1'b1;
         end else if (nmiClr_i) begin
            nmiPend_q <= 1'b0;
         end
      end
   end

   assign nmiPend_o = nmiPend_q;

endmodule

// File: rtl/r88_int_sequencer.sv
// Rocket88 reset/NMI/BRK/IRQ entry sequencer: fetches the reset vector, and at
// instruction boundaries pushes PC and flags, fetches a vector and loads the PC.
module r88_int_sequencer
   import r88_int_sequencer_pkg::*;
#(
   parameter logic [15:0] RESET_VEC = RESET_VEC_DEF,
   parameter logic [15:0] NMI_VEC   = NMI_VEC_DEF,
   parameter logic [15:0] IRQ_VEC   = IRQ_VEC_DEF
) (
   input  logic        sysClock,
   input  logic        resetReq,
   input  logic        nmiReq,
   input  logic        irq,
   input  logic        irqEn,
   input  logic        brkReq,
   input  logic        instrBoundary,
   input  logic [15:0] pcIn,
   input  logic [7:0]  flagsIn,
   input  logic [15:0] spAddr,
   input  logic [7:0]  memDataIn,
   input  logic        memAck,
   output logic        seqActive,
   output logic        memRead,
   output logic        memWrite,
   output logic [15:0] memAddr,
   output logic [7:0]  memDataOut,
   output logic        spDec,
   output logic        pcLoad,
   output logic [15:0] pcOut,
   output logic        irqDisable
);

   seq_state_e  state_q;
   logic        seqActive_q;
   logic        memRead_q;
   logic        memWrite_q;
   logic [15:0] memAddr_q;
   logic [7:0]  memDataOut_q;
   logic        spDec_q;
   logic        pcLoad_q;
   logic [15:0] pcOut_q;
   logic        irqDisable_q;

   logic [15:0] vec_q;
   logic [15:0] pc_q;
   logic [7:0]  flags_q;
   logic [7:0]  lo_q;

   logic        nmiPend;
   logic        atBoundary;
   logic        nmiTake;
   logic        brkTake;
   logic        irqTake;
   logic        accDone;
   logic [15:0] vec_d;
   logic [7:0]  flags_d;
   logic [15:0] pushAddr_d;

   r88_nmi_edge u_nmi_edge (
      .sysClock_i (sysClock),
      .resetReq_i (resetReq),
      .nmiReq_i   (nmiReq),
      .nmiClr_i   (nmiTake),
      .nmiPend_o  (nmiPend)
   );

   always_comb begin
      atBoundary = (state_q == IDLE) && instrBoundary;
      nmiTake    = atBoundary && nmiPend;
      brkTake    = atBoundary && !nmiPend && brkReq;
      irqTake    = atBoundary && !nmiPend && !brkReq && irq && irqEn;
      vec_d      = nmiTake ? NMI_VEC : IRQ_VEC;
      flags_d    = push_flags(flagsIn, brkTake);
      accDone    = (memRead_q || memWrite_q) && memAck;
      // Next push issues on the ack edge: the decoder has not yet applied the
      // decrement for the push just accepted, nor one still pulsing on spDec.
      pushAddr_d = spAddr - 16'd1 - {15'd0, spDec_q};
   end

   always_ff @(posedge sysClock) begin
      if (resetReq) begin
         state_q      <= RST_LO;
         seqActive_q  <= 1'b1;
         memRead_q    <= 1'b0;
         memWrite_q   <= 1'b0;
         memAddr_q    <= 16'h0000;
         memDataOut_q <= 8'h00;
         spDec_q      <= 1'b0;
         pcLoad_q     <= 1'b0;
         pcOut_q      <= 16'h0000;
         irqDisable_q <= 1'b0;
      end else begin
         spDec_q      <= 1'b0;
         pcLoad_q     <= 1'b0;
         irqDisable_q <= 1'b0;
         unique case (state_q)
            RST_LO: begin
               if (!memRead_q) begin
                  memRead_q <= 1'b1;
                  memAddr_q <= RESET_VEC;
               end else if (memAck) begin
                  lo_q      <= memDataIn;
                  memAddr_q <= RESET_VEC + 16'd1;
                  state_q   <= RST_HI;
               end
            end
            RST_HI, VEC_HI: begin
               if (accDone) begin
                  memRead_q    <= 1'b0;
                  pcOut_q      <= {memDataIn, lo_q};
                  pcLoad_q     <= 1'b1;
                  irqDisable_q <= 1'b1;
                  state_q      <= LOAD_PC;
               end
            end
            IDLE: begin
               if (nmiTake || brkTake || irqTake) begin
                  seqActive_q  <= 1'b1;
                  vec_q        <= vec_d;
                  pc_q         <= pcIn;
                  flags_q      <= flags_d;
                  memWrite_q   <= 1'b1;
                  memAddr_q    <= spAddr;
                  memDataOut_q <= pcIn[15:8];
                  state_q      <= PUSH_PCH;
               end
            end
            PUSH_PCH: begin
               if (accDone) begin
                  spDec_q      <= 1'b1;
                  memAddr_q    <= pushAddr_d;
                  memDataOut_q <= pc_q[7:0];
                  state_q      <= PUSH_PCL;
               end
            end
            PUSH_PCL: begin
               if (accDone) begin
                  spDec_q      <= 1'b1;
                  memAddr_q    <= pushAddr_d;
                  memDataOut_q <= flags_q;
                  state_q      <= PUSH_FLG;
               end
            end
            PUSH_FLG: begin
               if (accDone) begin
                  spDec_q    <= 1'b1;
                  memWrite_q <= 1'b0;
                  memRead_q  <= 1'b1;
                  memAddr_q  <= vec_q;
                  state_q    <= VEC_LO;
               end
            end
            VEC_LO: begin
               if (accDone) begin
                  lo_q      <= memDataIn;
                  memAddr_q <= vec_q + 16'd1;
                  state_q   <= VEC_HI;
               end
            end
            LOAD_PC: begin
               seqActive_q <= 1'b0;
               state_q     <= IDLE;
            end
            default: begin
               state_q <= RST_LO;
            end
         endcase
      end
   end

   assign seqActive  = seqActive_q;
   assign memRead    = memRead_q;
   assign memWrite   = memWrite_q;
   assign memAddr    = memAddr_q;
   assign memDataOut = memDataOut_q;
   assign spDec      = spDec_q;
   assign pcLoad     = pcLoad_q;
   assign pcOut      = pcOut_q;
   assign irqDisable = irqDisable_q;

endmodule

// File: tb/tb_r88_int_sequencer.sv
// Directed bench for r88_int_sequencer: small vector ROM, SP model driven by
// spDec, and logs of accepted reads/writes compared against hand-computed values.
module tb_r88_int_sequencer;

   logic        sysClock = 1'b0;
   logic        resetReq;
   logic        nmiReq;
   logic        irq;
   logic        irqEn;
   logic        brkReq;
   logic        instrBoundary;
   logic [15:0] pcIn;
   logic [7:0]  flagsIn;
   logic [15:0] spAddr;
   logic [7:0]  memDataIn;
   logic        memAck;
   logic        seqActive;
   logic        memRead;
   logic        memWrite;
   logic [15:0] memAddr;
   logic [7:0]  memDataOut;
   logic        spDec;
   logic        pcLoad;
   logic [15:0] pcOut;
   logic        irqDisable;

   int          nChecks = 0;
   int          nErrors = 0;
   int          cyc     = 0;
   int          bcyc    = 0;
   int          bothCnt = 0;
   logic [23:0] wrLog[$];
   logic [15:0] rdLog[$];

   r88_int_sequencer dut (
      .sysClock      (sysClock),
      .resetReq      (resetReq),
      .nmiReq        (nmiReq),
      .irq           (irq),
      .irqEn         (irqEn),
      .brkReq        (brkReq),
      .instrBoundary (instrBoundary),
      .pcIn          (pcIn),
      .flagsIn       (flagsIn),
      .spAddr        (spAddr),
      .memDataIn     (memDataIn),
      .memAck        (memAck),
      .seqActive     (seqActive),
      .memRead       (memRead),
      .memWrite      (memWrite),
      .memAddr       (memAddr),
      .memDataOut    (memDataOut),
      .spDec         (spDec),
      .pcLoad        (pcLoad),
      .pcOut         (pcOut),
      .irqDisable    (irqDisable)
   );

   always #5 sysClock = ~sysClock;

   function automatic logic [7:0] rom(input logic [15:0] a);
      case (a)
         16'hFFFC: return 8'h34;
         16'hFFFD: return 8'h12;
         16'hFFFE: return 8'h00;
         16'hFFFF: return 8'hC0;
         16'hFFFA: return 8'h00;
         16'hFFFB: return 8'h90;
         default:  return a[7:0] ^ 8'h5A;
      endcase
   endfunction

   assign memDataIn = rom(memAddr);

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Log the accesses of the current cycle, then advance to the next negedge.
   // A decrement seen on spDec lands after the edge that ends that cycle.
   task automatic tick();
      logic dec;
      if (memWrite === 1'b1 && memAck) wrLog.push_back({memAddr, memDataOut});
      if (memRead === 1'b1 && memAck) rdLog.push_back(memAddr);
      if (memRead === 1'b1 && memWrite === 1'b1) bothCnt++;
      dec = (spDec === 1'b1);
      @(negedge sysClock);
      cyc++;
      if (dec) spAddr = spAddr - 16'd1;
   endtask

   task automatic clear_logs();
      wrLog.delete();
      rdLog.delete();
   endtask

   task automatic boundary();
      instrBoundary = 1'b1;
      bcyc          = cyc;
      tick();
      instrBoundary = 1'b0;
   endtask

   task automatic run_until_pcload(input string tag, input int start, input int expLat);
      int n;
      n = 0;
      while (pcLoad !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check_eq({tag, "_lat"}, cyc - start, expLat);
   endtask

   task automatic chk_wr(input string tag, input int i, input logic [23:0] e);
      check_eq($sformatf("%s_wr%0d", tag, i), (i < wrLog.size()) ? {8'h00, wrLog[i]} : 32'hDEADBEEF, {8'h00, e});
   endtask

   task automatic chk_rd(input string tag, input int i, input logic [15:0] e);
      check_eq($sformatf("%s_rd%0d", tag, i), (i < rdLog.size()) ? {16'h0, rdLog[i]} : 32'hDEADBEEF, {16'h0, e});
   endtask

   task automatic chk_vec_fetch(input string tag, input logic [15:0] v, input logic [15:0] target);
      check_eq({tag, "_rdn"}, rdLog.size(), 2);
      chk_rd(tag, 0, v);
      chk_rd(tag, 1, v + 16'd1);
      check_eq({tag, "_pcout"}, pcOut, target);
      check_eq({tag, "_irqdis"}, irqDisable, 1'b1);
   endtask

   initial begin
      resetReq      = 1'b1;
      nmiReq        = 1'b0;
      irq           = 1'b0;
      irqEn         = 1'b0;
      brkReq        = 1'b0;
      instrBoundary = 1'b0;
      pcIn          = 16'h0000;
      flagsIn       = 8'h00;
      spAddr        = 16'h01FF;
      memAck        = 1'b1;

      // Reset state and reset-vector fetch
      repeat (3) tick();
      check_eq("rst_seq", seqActive, 1'b1);
      check_eq("rst_rd", memRead, 1'b0);
      check_eq("rst_wr", memWrite, 1'b0);
      check_eq("rst_pcl", pcLoad, 1'b0);
      check_eq("rst_spdec", spDec, 1'b0);
      check_eq("rst_addr", memAddr, 16'h0000);
      check_eq("rst_pcout", pcOut, 16'h0000);
      resetReq = 1'b0;
      clear_logs();
      run_until_pcload("reset", cyc, 3);
      chk_vec_fetch("reset", 16'hFFFC, 16'h1234);
      tick();
      check_eq("reset_seq_drop", seqActive, 1'b0);
      check_eq("reset_pcl_pulse", pcLoad, 1'b0);
      repeat (2) tick();
      check_eq("idle_seq", seqActive, 1'b0);

      // IRQ entry, irq dropped mid-sequence
      irq = 1'b1; irqEn = 1'b1; pcIn = 16'h8001; flagsIn = 8'hA5; spAddr = 16'h01FF;
      clear_logs();
      boundary();
      check_eq("irq_seq_c1", seqActive, 1'b1);
      check_eq("irq_addr_c1", memAddr, 16'h01FF);
      irq = 1'b0;
      run_until_pcload("irq", bcyc, 6);
      check_eq("irq_wrn", wrLog.size(), 3);
      chk_wr("irq", 0, 24'h01FF_80);
      chk_wr("irq", 1, 24'h01FE_01);
      chk_wr("irq", 2, 24'h01FD_A5);
      chk_vec_fetch("irq", 16'hFFFE, 16'hC000);
      tick();
      check_eq("irq_sp_end", spAddr, 16'h01FC);
      check_eq("irq_seq_drop", seqActive, 1'b0);

      // Masked IRQ ignored, then BRK taken with break bit forced
      irq = 1'b1; irqEn = 1'b0; pcIn = 16'h4567; flagsIn = 8'hA5; spAddr = 16'h0150;
      clear_logs();
      boundary();
      repeat (3) tick();
      check_eq("mask_seq", seqActive, 1'b0);
      check_eq("mask_wrn", wrLog.size(), 0);
      brkReq = 1'b1;
      boundary();
      brkReq = 1'b0;
      run_until_pcload("brk", bcyc, 6);
      check_eq("brk_wrn", wrLog.size(), 3);
      chk_wr("brk", 0, 24'h0150_45);
      chk_wr("brk", 1, 24'h014F_67);
      chk_wr("brk", 2, 24'h014E_B5);
      chk_vec_fetch("brk", 16'hFFFE, 16'hC000);
      tick();

      // NMI beats BRK and IRQ; second NMI edge mid-push stays pending
      nmiReq = 1'b1;
      tick();
      nmiReq = 1'b0;
      repeat (3) tick();
      irq = 1'b1; irqEn = 1'b1; brkReq = 1'b1; pcIn = 16'h1111; flagsIn = 8'hB5; spAddr = 16'h0200;
      clear_logs();
      boundary();
      brkReq = 1'b0; irq = 1'b0;
      nmiReq = 1'b1;
      tick();
      nmiReq = 1'b0;
      run_until_pcload("nmi", bcyc, 6);
      check_eq("nmi_wrn", wrLog.size(), 3);
      chk_wr("nmi", 0, 24'h0200_11);
      chk_wr("nmi", 1, 24'h01FF_11);
      chk_wr("nmi", 2, 24'h01FE_A5);
      chk_vec_fetch("nmi", 16'hFFFA, 16'h9000);
      tick();
      pcIn = 16'h2222; flagsIn = 8'h00;
      clear_logs();
      boundary();
      run_until_pcload("nmi2", bcyc, 6);
      chk_vec_fetch("nmi2", 16'hFFFA, 16'h9000);
      tick();
      clear_logs();
      boundary();
      repeat (3) tick();
      check_eq("nmi_clr_seq", seqActive, 1'b0);
      check_eq("nmi_clr_wrn", wrLog.size(), 0);

      // Wait states on PUSH_PCL
      irq = 1'b1; irqEn = 1'b1; pcIn = 16'hABCD; flagsIn = 8'h00; spAddr = 16'h0100;
      clear_logs();
      boundary();
      irq = 1'b0;
      tick();
      memAck = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_eq($sformatf("ws_wr%0d", i), memWrite, 1'b1);
         check_eq($sformatf("ws_addr%0d", i), memAddr, 16'h00FF);
         check_eq($sformatf("ws_data%0d", i), memDataOut, 8'hCD);
         if (i > 0) check_eq($sformatf("ws_spdec%0d", i), spDec, 1'b0);
         tick();
      end
      memAck = 1'b1;
      check_eq("ws_spdec_ack", spDec, 1'b0);
      tick();
      check_eq("ws_spdec_after", spDec, 1'b1);
      check_eq("ws_flg_addr", memAddr, 16'h00FE);
      run_until_pcload("ws", bcyc, 9);
      check_eq("ws_wrn", wrLog.size(), 3);
      chk_wr("ws", 0, 24'h0100_AB);
      chk_wr("ws", 1, 24'h00FF_CD);
      chk_wr("ws", 2, 24'h00FE_00);
      tick();

      // Reset during VEC_LO aborts the interrupt
      irq = 1'b1; irqEn = 1'b1; pcIn = 16'h0000; spAddr = 16'h0300;
      boundary();
      irq = 1'b0;
      repeat (3) tick();
      check_eq("abort_vlo_rd", memRead, 1'b1);
      check_eq("abort_vlo_addr", memAddr, 16'hFFFE);
      resetReq = 1'b1;
      tick();
      check_eq("abort_rd", memRead, 1'b0);
      check_eq("abort_wr", memWrite, 1'b0);
      check_eq("abort_pcl", pcLoad, 1'b0);
      check_eq("abort_seq", seqActive, 1'b1);
      tick();
      resetReq = 1'b0;
      clear_logs();
      run_until_pcload("rerst", cyc, 3);
      chk_vec_fetch("rerst", 16'hFFFC, 16'h1234);
      tick();

      check_eq("strobe_excl", bothCnt, 0);
      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
